// File: rtl/mult8_seq_ctrl_if.sv
// Request-side handshake bundle for the 8x8 sequential multiplier controller.
// master = requesting block, slave = controller.
interface mult8_seq_ctrl_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mult8_seq_ctrl.sv
// 8x8 unsigned multiply by four nibble passes through an external 4x4 combinational multiplier.
// Latency: 5 cycles from acceptance to done (PP_REG=0), 9 cycles (PP_REG=1); start ignored while busy.
module mult8_seq_ctrl #(
    parameter bit PP_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    mult8_seq_ctrl_if.slave   req,
    output logic [3:0]        mm,
    output logic [3:0]        mq,
    input  logic [7:0]        mp
);

    typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, FIN} state_t;

    state_t      state;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] acc;
    logic [7:0]  pp_q;
    logic        phase;
    logic        busy_q;
    logic        done_q;
    logic [15:0] product_q;

    logic [7:0]  pp_src;
    logic [15:0] term;
    logic        pass_add;

    assign req.busy    = busy_q;
    assign req.done    = done_q;
    assign req.product = product_q;

    // With the pipeline register the add happens in phase 1 on the captured value.
    assign pp_src   = PP_REG ? pp_q : mp;
    assign pass_add = PP_REG ? phase : 1'b1;

    always_comb begin
        mm = 4'h0;
        mq = 4'h0;
        case (state)
            P0: begin mm = ra[3:0]; mq = rb[3:0]; end
            P1: begin mm = ra[7:4]; mq = rb[3:0]; end
            P2: begin mm = ra[3:0]; mq = rb[7:4]; end
            P3: begin mm = ra[7:4]; mq = rb[7:4]; end
            default: begin mm = 4'h0; mq = 4'h0; end
        endcase
    end

    always_comb begin
        term = 16'h0000;
        case (state)
            P0:      term = {8'h00, pp_src};
            P1, P2:  term = {4'h0, pp_src, 4'h0};
            P3:      term = {pp_src, 8'h00};
            default: term = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ra        <= 8'h00;
            rb        <= 8'h00;
            acc       <= 16'h0000;
            pp_q      <= 8'h00;
            phase     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= 16'h0000;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req.start) begin
                        ra     <= req.a;
                        rb     <= req.b;
                        acc    <= 16'h0000;
                        phase  <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= P0;
                    end
                end
                P0, P1, P2, P3: begin
                    if (!pass_add) begin
                        pp_q  <= mp;
                        phase <= 1'b1;
                    end else begin
                        acc   <= acc + term;
                        phase <= 1'b0;
                        case (state)
                            P0:      state <= P1;
                            P1:      state <= P2;
                            P2:      state <= P3;
                            default: state <= FIN;
                        endcase
                        // Final term folded straight into product so it is valid alongside done.
                        if (state == P3) begin
                            product_q <= acc + term;
                            done_q    <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Bench for mult8_seq_ctrl: both PP_REG variants, each driving its own combinational 4x4 multiplier.
module tb_mult8_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult8_seq_ctrl_if if0 ();
    mult8_seq_ctrl_if if1 ();

    logic [3:0] mm0, mq0, mm1, mq1;
    logic [7:0] mp0, mp1;

    assign mp0 = {4'h0, mm0} * {4'h0, mq0};
    assign mp1 = {4'h0, mm1} * {4'h0, mq1};

    mult8_seq_ctrl #(.PP_REG(1'b0)) u0 (
        .clk (clk), .rst (rst), .req (if0), .mm (mm0), .mq (mq0), .mp (mp0)
    );
    mult8_seq_ctrl #(.PP_REG(1'b1)) u1 (
        .clk (clk), .rst (rst), .req (if1), .mm (mm1), .mq (mq1), .mp (mp1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input logic st, input logic [7:0] a, input logic [7:0] b);
        if (s) begin if1.start = st; if1.a = a; if1.b = b; end
        else   begin if0.start = st; if0.a = a; if0.b = b; end
    endtask

    function automatic logic [7:0] mmq(input bit s);
        return s ? {mm1, mq1} : {mm0, mq0};
    endfunction
    function automatic logic get_done(input bit s);
        return s ? if1.done : if0.done;
    endfunction
    function automatic logic get_busy(input bit s);
        return s ? if1.busy : if0.busy;
    endfunction
    function automatic logic [15:0] get_prod(input bit s);
        return s ? if1.product : if0.product;
    endfunction

    // One complete operation from IDLE; reference: product = a*b, nibble pairs
    // (alo,blo),(ahi,blo),(alo,bhi),(ahi,bhi), each held one cycle or two with PP_REG.
    task automatic do_op(input bit s, input logic [7:0] a, input logic [7:0] b);
        int n;
        int per;
        logic [7:0] prs [4];
        per = s ? 2 : 1;
        prs[0] = {a[3:0], b[3:0]};
        prs[1] = {a[7:4], b[3:0]};
        prs[2] = {a[3:0], b[7:4]};
        prs[3] = {a[7:4], b[7:4]};
        drive(s, 1'b1, a, b);
        tick();
        drive(s, 1'b0, 8'($urandom), 8'($urandom));
        n = 1;
        while (!get_done(s) && n <= 12) begin
            if (n <= 4 * per) chk("mm_mq", {24'h0, mmq(s)}, {24'h0, prs[(n - 1) / per]});
            tick();
            n++;
        end
        chk("latency", n, 4 * per + 1);
        chk("product", {16'h0, get_prod(s)}, {16'h0, 16'(a) * 16'(b)});
        chk("busy_at_done", {31'h0, get_busy(s)}, 32'h1);
        chk("mm_mq_fin", {24'h0, mmq(s)}, 32'h0);
        tick();
        chk("done_one_cycle", {31'h0, get_done(s)}, 32'h0);
        chk("idle_not_busy", {31'h0, get_busy(s)}, 32'h0);
        chk("product_held", {16'h0, get_prod(s)}, {16'h0, 16'(a) * 16'(b)});
    endtask

    initial begin
        int last;
        int dn;
        bit seen;

        rst = 1'b1;
        drive(0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        chk("rst_busy0", {31'h0, if0.busy}, 32'h0);
        chk("rst_done0", {31'h0, if0.done}, 32'h0);
        chk("rst_prod0", {16'h0, if0.product}, 32'h0);
        chk("rst_mmq0", {24'h0, mm0, mq0}, 32'h0);
        chk("rst_busy1", {31'h0, if1.busy}, 32'h0);
        chk("rst_prod1", {16'h0, if1.product}, 32'h0);
        rst = 1'b0;
        tick();

        do_op(0, 8'h12, 8'h34);
        chk("prod_12x34", {16'h0, if0.product}, 32'h03A8);
        do_op(0, 8'hFF, 8'hFF);
        chk("prod_ffxff", {16'h0, if0.product}, 32'hFE01);
        do_op(0, 8'hA5, 8'h00);

        // start held high: accepted once per 6 cycles, mid-op operand changes ignored
        drive(0, 1'b1, 8'h0F, 8'h10);
        last = -1;
        dn = 0;
        for (int c = 0; c < 26; c++) begin
            tick();
            if (if0.done) begin
                chk("b2b_product", {16'h0, if0.product}, 32'h00F0);
                if (last >= 0) chk("b2b_period", c - last, 6);
                last = c;
                dn++;
            end
            if (if0.busy) drive(0, 1'b1, 8'hFF, 8'h77);
            else          drive(0, 1'b1, 8'h0F, 8'h10);
        end
        chk("b2b_count", dn, 4);
        drive(0, 1'b0, 8'h00, 8'h00);
        for (int c = 0; c < 10; c++) tick();
        chk("b2b_final_prod", {16'h0, if0.product}, 32'h00F0);

        // reset in P2 aborts the operation
        drive(0, 1'b1, 8'h12, 8'h34);
        tick();
        drive(0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        chk("p2_mm_mq", {24'h0, mm0, mq0}, 32'h23);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {31'h0, if0.busy}, 32'h0);
        chk("abort_done", {31'h0, if0.done}, 32'h0);
        chk("abort_prod", {16'h0, if0.product}, 32'h0);
        chk("abort_mmq", {24'h0, mm0, mq0}, 32'h0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (if0.done || if0.busy) seen = 1'b1;
        end
        chk("no_late_done", {31'h0, seen}, 32'h0);

        do_op(1, 8'hC3, 8'h5A);
        for (int i = 0; i < 1000; i++) do_op(1, 8'($urandom), 8'($urandom));
        for (int i = 0; i < 200; i++)  do_op(0, 8'($urandom), 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
